// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: memory-side controller for a 2-way, 16-set, 4-word-line
// write-through L1 data cache. It handles read-miss line refills, forwards
// stores to memory, keeps a 1-bit per-set LRU and stalls the CPU while busy.
// Optional feature macro: CRIT_WORD_FIRST_EN (refill starts at the missed word).
module cache_refill_ctrl #(
    parameter int NUM_SETS    = 16,
    parameter int BLOCK_WORDS = 4,
    parameter int TAG_BITS    = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_cpu_req,
    input  logic                        i_cpu_we,
    input  logic [31:0]                 i_cpu_addr,
    input  logic [31:0]                 i_cpu_wdata,
    input  logic                        i_cache_hit,
    input  logic                        i_cache_hit_way,
    output logic                        o_stall,
    output logic                        o_fill_valid,
    output logic [3:0]                  o_fill_set,
    output logic                        o_fill_way,
    output logic [TAG_BITS-1:0]         o_fill_tag,
    output logic [32*BLOCK_WORDS-1:0]   o_fill_data,
    output logic                        o_mem_req_valid,
    input  logic                        i_mem_req_ready,
    output logic                        o_mem_req_we,
    output logic [31:0]                 o_mem_req_addr,
    output logic [31:0]                 o_mem_req_wdata,
    input  logic                        i_mem_rsp_valid,
    input  logic [31:0]                 i_mem_rsp_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_RD_REQ, S_RD_RSP, S_FILL, S_DONE
    } state_t;

    state_t                      r_state;
    logic [27:0]                 r_line_addr;   // byte addr[31:4] of the missed line
    logic [1:0]                  r_k;           // word slot currently being fetched
    logic [1:0]                  r_cnt;         // responses already received
    logic [31:0]                 r_line [0:BLOCK_WORDS-1];
    logic [NUM_SETS-1:0]         r_lru;         // per set: way to evict next
    logic                        r_fill_valid;
    logic [3:0]                  r_fill_set;
    logic                        r_fill_way;
    logic [TAG_BITS-1:0]         r_fill_tag;
    logic [32*BLOCK_WORDS-1:0]   r_fill_data;
    logic                        r_mem_valid;
    logic                        r_mem_we;
    logic [31:0]                 r_mem_addr;
    logic [31:0]                 r_mem_wdata;

    logic [3:0]                  w_cpu_set;
    logic [1:0]                  w_first_k;
    logic [32*BLOCK_WORDS-1:0]   w_line_next;
    logic                        w_unused_ok;

    assign w_cpu_set   = i_cpu_addr[7:4];
    // Byte-lane bits never reach memory: requests are word aligned.
    assign w_unused_ok = &{1'b0, i_cpu_addr[1:0]};

`ifdef CRIT_WORD_FIRST_EN
    assign w_first_k = i_cpu_addr[3:2];
`else
    assign w_first_k = 2'd0;
`endif

    // Line as it looks once the word arriving this cycle lands in its slot.
    generate
        for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_line
            assign w_line_next[32*gi +: 32] = (r_k == 2'(gi)) ? i_mem_rsp_data : r_line[gi];
        end
    endgenerate

    // Stall: busy in every state except DONE; in IDLE only for misses and stores.
    always_comb begin
        o_stall = 1'b0;
        case (r_state)
            S_IDLE:  o_stall = i_cpu_req && (i_cpu_we || !i_cache_hit);
            S_DONE:  o_stall = 1'b0;
            default: o_stall = 1'b1;
        endcase
    end

    // Main FSM with registered memory-request and fill outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_line_addr  <= '0;
            r_k          <= '0;
            r_cnt        <= '0;
            r_lru        <= '0;
            r_fill_valid <= 1'b0;
            r_fill_set   <= '0;
            r_fill_way   <= 1'b0;
            r_fill_tag   <= '0;
            r_fill_data  <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++) r_line[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_req && i_cpu_we) begin
                        if (i_cache_hit) r_lru[w_cpu_set] <= ~i_cache_hit_way;
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {i_cpu_addr[31:2], 2'b00};
                        r_mem_wdata <= i_cpu_wdata;
                        r_state     <= S_WR_REQ;
                    end else if (i_cpu_req && !i_cache_hit) begin
                        r_line_addr <= i_cpu_addr[31:4];
                        r_k         <= w_first_k;
                        r_cnt       <= 2'd0;
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= {i_cpu_addr[31:4], w_first_k, 2'b00};
                        r_mem_wdata <= '0;
                        r_state     <= S_RD_REQ;
                    end else if (i_cpu_req) begin
                        r_lru[w_cpu_set] <= ~i_cache_hit_way;
                    end
                end
                S_WR_REQ: begin
                    if (i_mem_req_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_RD_REQ: begin
                    if (i_mem_req_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_RD_RSP;
                    end
                end
                S_RD_RSP: begin
                    if (i_mem_rsp_valid) begin
                        r_line[r_k] <= i_mem_rsp_data;
                        if (r_cnt == 2'd3) begin
                            r_fill_valid <= 1'b1;
                            r_fill_set   <= r_line_addr[3:0];
                            r_fill_way   <= r_lru[r_line_addr[3:0]];
                            r_fill_tag   <= r_line_addr[27:4];
                            r_fill_data  <= w_line_next;
                            r_state      <= S_FILL;
                        end else begin
                            r_k         <= r_k + 2'd1;
                            r_cnt       <= r_cnt + 2'd1;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= {r_line_addr, r_k + 2'd1, 2'b00};
                            r_state     <= S_RD_REQ;
                        end
                    end
                end
                S_FILL: begin
                    r_fill_valid        <= 1'b0;
                    r_lru[r_fill_set]   <= ~r_fill_way;
                    r_state             <= S_DONE;
                end
                S_DONE: begin
                    // One dead cycle so the still-held request does not retrigger.
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fill_valid    = r_fill_valid;
    assign o_fill_set      = r_fill_set;
    assign o_fill_way      = r_fill_way;
    assign o_fill_tag      = r_fill_tag;
    assign o_fill_data     = r_fill_data;
    assign o_mem_req_valid = r_mem_valid;
    assign o_mem_req_we    = r_mem_we;
    assign o_mem_req_addr  = r_mem_addr;
    assign o_mem_req_wdata = r_mem_wdata;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Testbench for cache_refill_ctrl: directed cases plus randomized traffic,
// checked against a transaction-level reference model (request lists, line
// contents and a per-set LRU array).
module tb_cache_refill_ctrl;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, cache_hit, cache_hit_way;
    logic [31:0]   cpu_addr, cpu_wdata;
    logic          stall, fill_valid, fill_way;
    logic [3:0]    fill_set;
    logic [23:0]   fill_tag;
    logic [127:0]  fill_data;
    logic          mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]   mem_req_addr, mem_req_wdata;
    logic          mem_rsp_valid;
    logic [31:0]   mem_rsp_data;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_cpu_req       (cpu_req),
        .i_cpu_we        (cpu_we),
        .i_cpu_addr      (cpu_addr),
        .i_cpu_wdata     (cpu_wdata),
        .i_cache_hit     (cache_hit),
        .i_cache_hit_way (cache_hit_way),
        .o_stall         (stall),
        .o_fill_valid    (fill_valid),
        .o_fill_set      (fill_set),
        .o_fill_way      (fill_way),
        .o_fill_tag      (fill_tag),
        .o_fill_data     (fill_data),
        .o_mem_req_valid (mem_req_valid),
        .i_mem_req_ready (mem_req_ready),
        .o_mem_req_we    (mem_req_we),
        .o_mem_req_addr  (mem_req_addr),
        .o_mem_req_wdata (mem_req_wdata),
        .i_mem_rsp_valid (mem_rsp_valid),
        .i_mem_rsp_data  (mem_rsp_data)
    );

    int            total = 0;
    int            bad   = 0;
    bit            lru_m [16];
    bit            mem_a0 = 1'b0;
    logic [31:0]   obs_q [$];
    logic [127:0]  last_fill = '0;
    logic          last_way  = 1'b0;
    int            sc;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Main memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_a0) return 32'hA0 + {28'd0, a[3:2]};
        return {a[15:0] ^ 16'hC3A5, a[15:2], 2'b11};
    endfunction

    task automatic do_abort();
        rst_n = 1'b0; cpu_req = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
        #1;
        chk("rst_valid", mem_req_valid, 1'b0);
        chk("rst_fill", fill_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_F00D;
        @(negedge clk);
        chk("late_rsp_valid", mem_req_valid, 1'b0);
        chk("late_rsp_fill", fill_valid, 1'b0);
        chk("late_rsp_stall", stall, 1'b0);
        @(posedge clk); #1 mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("late_rsp_fill2", fill_valid, 1'b0);
        chk("late_rsp_valid2", mem_req_valid, 1'b0);
        for (int i = 0; i < 16; i++) lru_m[i] = 1'b0;
        $display("txn abort: reset during refill, late response dropped");
    endtask

    // One CPU access: builds the expected request list / fill from the model,
    // plays the memory side and checks everything the DUT emits.
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input bit hit, input bit hway, input int rdy_pct, input int dly_max,
                           input int hold_idx, input int abort_after, output int stall_cyc);
        logic [31:0]  exp_q [$];
        logic [31:0]  pend_q [$];
        int           due_q [$];
        logic [3:0]   set;
        logic [1:0]   o;
        logic [31:0]  e;
        bit           exp_fill = 1'b0;
        bit           exp_way = 1'b0;
        logic [127:0] exp_data = '0;
        int           req_idx = 0, hold_left = 5, rsp_done = 0, fills = 0;
        bit           prev_stuck = 1'b0, done = 1'b0;
        logic [31:0]  prev_addr = '0;
        set = addr[7:4];
        obs_q.delete();
        stall_cyc = 0;
        if (we) begin
            exp_q.push_back({addr[31:2], 2'b00});
            if (hit) lru_m[set] = ~hway;
        end else if (hit) begin
            lru_m[set] = ~hway;
        end else begin
`ifdef CRIT_WORD_FIRST_EN
            o = addr[3:2];
`else
            o = 2'd0;
`endif
            for (int i = 0; i < 4; i++) exp_q.push_back({addr[31:4], o + i[1:0], 2'b00});
            for (int i = 0; i < 4; i++) exp_data[32*i +: 32] = mem_word({addr[31:4], i[1:0], 2'b00});
            exp_fill = 1'b1;
            exp_way  = lru_m[set];
            lru_m[set] = ~exp_way;
        end
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        cache_hit = hit; cache_hit_way = hway;
        mem_req_ready = ($urandom_range(1, 100) <= rdy_pct);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (stall) stall_cyc++;
            if (prev_stuck) begin
                chk("hold_valid", mem_req_valid, 1'b1);
                chk("hold_addr", mem_req_addr, prev_addr);
            end
            if (mem_req_valid) begin
                if (mem_req_ready) begin
                    obs_q.push_back(mem_req_addr);
                    if (exp_q.size() == 0) chk("extra_req", 1'b1, 1'b0);
                    else begin
                        e = exp_q.pop_front();
                        chk("req_addr", mem_req_addr, e);
                        chk("req_we", mem_req_we, we);
                        if (we) chk("req_wdata", mem_req_wdata, wd);
                    end
                    if (!mem_req_we) begin
                        pend_q.push_back(mem_req_addr);
                        due_q.push_back(cyc + 1 + int'($urandom_range(0, dly_max)));
                    end
                    req_idx++;
                end else if (req_idx == hold_idx && hold_left > 0) begin
                    hold_left--;
                end
                prev_stuck = !mem_req_ready;
                prev_addr  = mem_req_addr;
            end else begin
                prev_stuck = 1'b0;
            end
            if (fill_valid) begin
                fills++;
                last_fill = fill_data;
                last_way  = fill_way;
                if (!exp_fill) chk("unexp_fill", 1'b1, 1'b0);
                else begin
                    chk("fill_set", fill_set, set);
                    chk("fill_way", fill_way, exp_way);
                    chk("fill_tag", fill_tag, addr[31:8]);
                    chk("fill_data", fill_data, exp_data);
                end
            end
            if (!stall) done = 1'b1;
            else begin
                @(posedge clk); #1;
                if (abort_after > 0 && rsp_done == abort_after) begin
                    do_abort();
                    return;
                end
                mem_req_ready = (req_idx == hold_idx && hold_left > 0) ? 1'b0
                              : ($urandom_range(1, 100) <= rdy_pct);
                if (pend_q.size() > 0 && due_q[0] <= cyc + 1) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(pend_q.pop_front());
                    void'(due_q.pop_front());
                    rsp_done++;
                end else begin
                    mem_rsp_valid = 1'b0;
                    mem_rsp_data  = $urandom;
                end
            end
        end
        if (!done) chk("timeout", 1'b0, 1'b1);
        chk("reqs_left", exp_q.size(), 0);
        chk("fill_count", fills, exp_fill ? 1 : 0);
        // Request still held during the DONE cycle must not retrigger.
        @(posedge clk); #1;
        cpu_req = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        chk("post_valid", mem_req_valid, 1'b0);
        chk("post_stall", stall, 1'b0);
        $display("txn we=%0d addr=%08h hit=%0d way=%0d reqs=%0d fills=%0d stall_cycles=%0d",
                 we, addr, hit, hway, obs_q.size(), fills, stall_cyc);
    endtask

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cache_hit = 1'b0; cache_hit_way = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        for (int i = 0; i < 16; i++) lru_m[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_stall", stall, 1'b0);
        chk("reset_valid", mem_req_valid, 1'b0);
        chk("reset_fill_valid", fill_valid, 1'b0);
        chk("reset_fill_data", fill_data, 128'd0);
        chk("reset_req_addr", mem_req_addr, 32'd0);

        // Read miss, zero-wait memory.
        mem_a0 = 1'b1;
        run_txn(1'b0, 32'h0000_1234, '0, 1'b0, 1'b0, 100, 0, -1, 0, sc);
        chk("miss_stall_cycles", sc, 10);
        chk("miss_nreq", obs_q.size(), 4);
`ifdef CRIT_WORD_FIRST_EN
        chk("miss_order0", obs_q[0], 32'h1234);
        chk("miss_order3", obs_q[3], 32'h1230);
`else
        chk("miss_order0", obs_q[0], 32'h1230);
        chk("miss_order3", obs_q[3], 32'h123C);
`endif
        chk("miss_line", last_fill, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("miss_way", last_way, 1'b0);

        // Stores with and without hit.
        run_txn(1'b1, 32'h0000_0040, 32'hDEADBEEF, 1'b1, 1'b0, 100, 0, -1, 0, sc);
        chk("store_hit_stall", sc, 2);
        chk("store_hit_addr", obs_q[0], 32'h40);
        run_txn(1'b1, 32'h0000_0040, 32'hDEADBEEF, 1'b0, 1'b0, 100, 0, -1, 0, sc);
        chk("store_miss_stall", sc, 2);

        // LRU on set 3.
        run_txn(1'b0, 32'h0000_1234, '0, 1'b1, 1'b0, 100, 0, -1, 0, sc);
        chk("hit_stall", sc, 0);
        run_txn(1'b0, 32'h0000_2230, '0, 1'b0, 1'b0, 100, 0, -1, 0, sc);
        chk("lru_first_miss_way", last_way, 1'b1);
        run_txn(1'b0, 32'h0000_3234, '0, 1'b0, 1'b0, 100, 0, -1, 0, sc);
        chk("lru_second_miss_way", last_way, 1'b0);

        // Backpressure on word 1.
        run_txn(1'b0, 32'h0000_4430, '0, 1'b0, 1'b0, 100, 0, 1, 0, sc);
        chk("bp_nreq", obs_q.size(), 4);
        chk("bp_stall", sc, 15);

`ifdef CRIT_WORD_FIRST_EN
        run_txn(1'b0, 32'h0000_1238, '0, 1'b0, 1'b0, 100, 0, -1, 0, sc);
        chk("cwf_order0", obs_q[0], 32'h1238);
        chk("cwf_order1", obs_q[1], 32'h123C);
        chk("cwf_order2", obs_q[2], 32'h1230);
        chk("cwf_order3", obs_q[3], 32'h1234);
        chk("cwf_line", last_fill, 128'h000000A3_000000A2_000000A1_000000A0);
`endif

        // Reset in the middle of a refill, after set 3 LRU points at way 1.
        run_txn(1'b0, 32'h0000_1234, '0, 1'b1, 1'b0, 100, 0, -1, 0, sc);
        run_txn(1'b0, 32'h0000_5234, '0, 1'b0, 1'b0, 100, 0, -1, 2, sc);
        run_txn(1'b0, 32'h0000_6234, '0, 1'b0, 1'b0, 100, 0, -1, 0, sc);
        chk("after_reset_way", last_way, 1'b0);

        // Randomized traffic with random ready and response delays.
        mem_a0 = 1'b0;
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            a = {20'h0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom)};
            a[31:24] = 8'($urandom_range(0, 1));
            run_txn(1'($urandom), a, $urandom, 1'($urandom), 1'($urandom),
                    $urandom_range(30, 100), $urandom_range(0, 3), -1, 0, sc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
